// File: rtl/vec_irq_pkg.sv
// Shared types and constants for the vectored interrupt controller.
// States are plain 2-bit localparams so older tools can consume them.
package vec_irq_pkg;

  localparam int VEC_W     = 16;
  localparam int N_SRC_MAX = 8;
  localparam int DLY_W     = 3;
  localparam int IDX_W     = 3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_VEC   = 2'd1;
  localparam state_t ST_ACK   = 2'd2;
  localparam state_t ST_NOREQ = 2'd3;

  function automatic logic [N_SRC_MAX-1:0] onehot(
    input logic [IDX_W-1:0] idx
  );
    return N_SRC_MAX'(1) << idx;
  endfunction

endpackage

// File: rtl/vec_irq_prio.sv
// Fixed-priority encoder: lowest set index wins.
// Purely combinational; used for both winner pick and virq.
module vec_irq_prio
  import vec_irq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    any = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/vec_irq_ctrl.sv
// Vectored interrupt controller, responder side of istb/ivec/iack.
// Optional VIRQ_MASK_EN adds an irq_mask input gating eligibility.
module vec_irq_ctrl
  import vec_irq_pkg::*;
#(
  parameter int N_SRC   = 4,
  parameter int ACK_DLY = 1
) (
  input  logic                   clk_p,
  input  logic                   rst_n,
  input  logic                   vm_init,
  input  logic [N_SRC-1:0]       irq_req,
  input  logic [VEC_W*N_SRC-1:0] irq_vec,
`ifdef VIRQ_MASK_EN
  input  logic [N_SRC-1:0]       irq_mask,
`endif
  output logic [N_SRC-1:0]       irq_ack,
  output logic                   virq,
  input  logic                   istb,
  output logic [VEC_W-1:0]       ivec,
  output logic                   iack
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [DLY_W-1:0]   dly_q, dly_d, dly_inc;
  logic [VEC_W-1:0]   ivec_q, ivec_d;
  logic               iack_q, iack_d;
  logic [N_SRC-1:0]   irq_ack_q, irq_ack_d;
  logic               virq_q, virq_d;

  logic [N_SRC-1:0]   elig, elig_nw, win_oh;
  logic               busy;
  logic               win_any, nw_any;
  logic [IDX_W-1:0]   win_idx, nw_idx_unused;
  logic [VEC_W-1:0]   sel_vec;

`ifdef VIRQ_MASK_EN
  assign elig = irq_req & irq_mask;
`else
  assign elig = irq_req;
`endif

  assign win_oh  = N_SRC'(onehot(win_q));
  assign busy    = (state_q == ST_VEC) || (state_q == ST_ACK);
  // The source being serviced must not hold virq up on its own.
  assign elig_nw = busy ? (elig & ~win_oh) : elig;
  assign sel_vec = irq_vec[VEC_W*win_idx +: VEC_W];
  assign dly_inc = dly_q + DLY_W'(1);

  vec_irq_prio #(.N(N_SRC)) u_win (
    .req (elig),
    .any (win_any),
    .idx (win_idx)
  );

  vec_irq_prio #(.N(N_SRC)) u_virq (
    .req (elig_nw),
    .any (nw_any),
    .idx (nw_idx_unused)
  );

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    dly_d     = dly_q;
    ivec_d    = ivec_q;
    iack_d    = iack_q;
    irq_ack_d = '0;
    virq_d    = nw_any;
    if (vm_init) begin
      state_d = ST_IDLE;
      win_d   = '0;
      dly_d   = '0;
      ivec_d  = '0;
      iack_d  = 1'b0;
      virq_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (istb && win_any) begin
            state_d = ST_VEC;
            win_d   = win_idx;
            dly_d   = '0;
            ivec_d  = sel_vec;
          end else if (istb) begin
            state_d = ST_NOREQ;
          end
        end
        ST_VEC: begin
          if (!istb) begin
            state_d = ST_IDLE;
            dly_d   = '0;
            ivec_d  = '0;
          end else if (dly_inc == DLY_W'(ACK_DLY)) begin
            state_d = ST_ACK;
            dly_d   = '0;
            iack_d  = 1'b1;
          end else begin
            dly_d = dly_inc;
          end
        end
        ST_ACK: begin
          if (!istb) begin
            state_d   = ST_IDLE;
            ivec_d    = '0;
            iack_d    = 1'b0;
            irq_ack_d = win_oh;
          end
        end
        ST_NOREQ: begin
          if (!istb) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      win_q     <= '0;
      dly_q     <= '0;
      ivec_q    <= '0;
      iack_q    <= 1'b0;
      irq_ack_q <= '0;
      virq_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      dly_q     <= dly_d;
      ivec_q    <= ivec_d;
      iack_q    <= iack_d;
      irq_ack_q <= irq_ack_d;
      virq_q    <= virq_d;
    end
  end

  assign ivec    = ivec_q;
  assign iack    = iack_q;
  assign irq_ack = irq_ack_q;
  assign virq    = virq_q;

endmodule

// File: tb/tb_vec_irq_ctrl.sv
// Scoreboard bench for vec_irq_ctrl: expected vector/ack pushed per strobe,
// popped by a monitor when iack rises; scenarios check timing and virq.
module tb_vec_irq_ctrl;

  localparam int N   = 4;
  localparam int DLY = 2;

  typedef struct {
    logic [15:0]  vec;
    logic [N-1:0] ack;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            vm_init = 1'b0;
  logic [N-1:0]    irq_req = '0;
  logic [16*N-1:0] irq_vec;
`ifdef VIRQ_MASK_EN
  logic [N-1:0]    irq_mask = '1;
`endif
  logic [N-1:0]    irq_ack;
  logic            virq;
  logic            istb = 1'b0;
  logic [15:0]     ivec;
  logic            iack;

  int   checks = 0;
  int   fails  = 0;
  exp_t sb[$];

  logic [15:0]  cur_vec = '0;
  logic [N-1:0] pend_ack = '0;
  bit           pend = 0;
  logic         iack_prev = 1'b0;

  vec_irq_ctrl #(.N_SRC(N), .ACK_DLY(DLY)) dut (
    .clk_p   (clk),
    .rst_n   (rst_n),
    .vm_init (vm_init),
    .irq_req (irq_req),
    .irq_vec (irq_vec),
`ifdef VIRQ_MASK_EN
    .irq_mask(irq_mask),
`endif
    .irq_ack (irq_ack),
    .virq    (virq),
    .istb    (istb),
    .ivec    (ivec),
    .iack    (iack)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] vexp(input int i);
    return 16'((i + 1) * 16);
  endfunction

  // Monitor: pop on iack rise, hold vector while iack high, match irq_ack.
  always @(negedge clk) begin
    if (rst_n) begin
      if (iack && !iack_prev) begin
        checks++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL sb_underflow: iack rose with ivec=%o, nothing expected", ivec);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (ivec !== e.vec) begin
            fails++;
            $display("FAIL ivec: got %o want %o", ivec, e.vec);
          end
          cur_vec  = e.vec;
          pend_ack = e.ack;
          pend     = 1;
        end
      end else if (iack) begin
        checks++;
        if (ivec !== cur_vec) begin
          fails++;
          $display("FAIL ivec_stable: got %o want %o", ivec, cur_vec);
        end
      end
      if (irq_ack !== '0) begin
        checks++;
        if (!pend || irq_ack !== pend_ack) begin
          fails++;
          $display("FAIL irq_ack: got %b want %b (pending=%0d)", irq_ack, pend_ack, pend);
        end
        pend = 0;
      end
    end
    iack_prev = iack;
  end

  task automatic strobe(input bit pre, input logic [N-1:0] raise,
                        input logic [N-1:0] drop, output int lat,
                        output logic vq, output int ackn,
                        output logic [16:0] after);
    logic [N-1:0] seen;
    if (!pre) begin
      @(negedge clk);
      istb = 1'b1;
    end
    lat = 0;
    @(negedge clk);
    if (iack) lat = 1;
    irq_req = (irq_req | raise) & ~drop;
    for (int i = 2; i <= 64 && lat == 0; i++) begin
      @(negedge clk);
      if (iack) lat = i;
    end
    vq   = virq;
    istb = 1'b0;
    ackn = 0;
    seen = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) after = {iack, ivec};
      if (irq_ack != '0) ackn++;
      seen |= irq_ack;
    end
    irq_req &= ~seen;
  endtask

  task automatic test_reset();
    int lat, ackn;
    logic vq;
    logic [16:0] aft;
    rst_n   = 1'b0;
    istb    = 1'b1;
    irq_req = 4'b0100;
    repeat (2) @(negedge clk);
    checks++;
    if ({ivec, iack, virq, irq_ack} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got ivec=%o iack=%b virq=%b ack=%b want 0",
               ivec, iack, virq, irq_ack);
    end
    sb.push_back('{vexp(2), 4'b0100});
    rst_n = 1'b1;
    strobe(1, '0, '0, lat, vq, ackn, aft);
    checks++;
    if (lat !== 1 + DLY) begin
      fails++;
      $display("FAIL reset_strobe_latency: got %0d want %0d", lat, 1 + DLY);
    end
    checks++;
    if (ackn !== 1) begin
      fails++;
      $display("FAIL reset_ack_count: got %0d want 1", ackn);
    end
  endtask

  task automatic test_single();
    int lat, ackn;
    logic vq;
    logic [16:0] aft;
    @(negedge clk);
    irq_req = 4'b0100;
    @(negedge clk);
    checks++;
    if (virq !== 1'b1) begin
      fails++;
      $display("FAIL single_virq_pre: got %b want 1", virq);
    end
    sb.push_back('{vexp(2), 4'b0100});
    strobe(0, '0, '0, lat, vq, ackn, aft);
    checks++;
    if (lat !== 1 + DLY) begin
      fails++;
      $display("FAIL single_latency: got %0d want %0d", lat, 1 + DLY);
    end
    checks++;
    if (vq !== 1'b0) begin
      fails++;
      $display("FAIL single_virq_ack: got %b want 0", vq);
    end
    checks++;
    if (ackn !== 1) begin
      fails++;
      $display("FAIL single_ack_count: got %0d want 1", ackn);
    end
    checks++;
    if (aft !== 17'd0) begin
      fails++;
      $display("FAIL single_release: got iack/ivec=%h want 0", aft);
    end
  endtask

  task automatic test_pending();
    int lat, ackn;
    logic vq;
    logic [16:0] aft;
    irq_req = 4'b1010;
    sb.push_back('{vexp(1), 4'b0010});
    strobe(0, '0, '0, lat, vq, ackn, aft);
    checks++;
    if (vq !== 1'b1) begin
      fails++;
      $display("FAIL pending_virq_ack: got %b want 1", vq);
    end
    sb.push_back('{vexp(3), 4'b1000});
    strobe(0, '0, '0, lat, vq, ackn, aft);
    checks++;
    if (vq !== 1'b0 || lat !== 1 + DLY) begin
      fails++;
      $display("FAIL pending_second: got virq=%b lat=%0d want 0/%0d", vq, lat, 1 + DLY);
    end
  endtask

  task automatic test_noreq();
    logic seen_iack;
    logic [15:0] seen_vec;
    int lat, ackn;
    logic vq;
    logic [16:0] aft;
    irq_req   = '0;
    seen_iack = 1'b0;
    seen_vec  = '0;
    @(negedge clk);
    istb = 1'b1;
    repeat (64) begin
      @(negedge clk);
      seen_iack |= iack;
      seen_vec  |= ivec;
    end
    checks++;
    if (seen_iack !== 1'b0 || seen_vec !== '0) begin
      fails++;
      $display("FAIL noreq: got iack=%b ivec=%o want 0/0", seen_iack, seen_vec);
    end
    istb = 1'b0;
    repeat (2) @(negedge clk);
    irq_req = 4'b0010;
    sb.push_back('{vexp(1), 4'b0010});
    strobe(0, '0, '0, lat, vq, ackn, aft);
    checks++;
    if (lat !== 1 + DLY) begin
      fails++;
      $display("FAIL noreq_recover: got latency %0d want %0d", lat, 1 + DLY);
    end
  endtask

  task automatic test_vm_init();
    int lat, ackn, spur;
    logic vq;
    logic [16:0] aft;
    bit got;
    irq_req = 4'b0100;
    sb.push_back('{vexp(2), 4'b0100});
    @(negedge clk);
    istb = 1'b1;
    got  = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = iack;
    end
    checks++;
    if (!got) begin
      fails++;
      $display("FAIL vm_iack_timeout: got no iack want iack within 20");
    end
    vm_init = 1'b1;
    istb    = 1'b0;
    @(negedge clk);
    vm_init = 1'b0;
    pend    = 0;
    checks++;
    if ({iack, ivec, irq_ack} !== '0) begin
      fails++;
      $display("FAIL vm_init_clear: got iack=%b ivec=%o ack=%b want 0",
               iack, ivec, irq_ack);
    end
    spur = 0;
    repeat (4) begin
      @(negedge clk);
      if (irq_ack !== '0) spur++;
    end
    checks++;
    if (spur !== 0) begin
      fails++;
      $display("FAIL vm_no_ack: got %0d ack cycles want 0", spur);
    end
    sb.push_back('{vexp(2), 4'b0100});
    strobe(0, '0, '0, lat, vq, ackn, aft);
    checks++;
    if (ackn !== 1) begin
      fails++;
      $display("FAIL vm_after: got %0d ack cycles want 1", ackn);
    end
  endtask

  task automatic test_freeze();
    int lat, ackn;
    logic vq;
    logic [16:0] aft;
    irq_req = 4'b0100;
    sb.push_back('{vexp(2), 4'b0100});
    strobe(0, 4'b0001, '0, lat, vq, ackn, aft);
    checks++;
    if (vq !== 1'b1) begin
      fails++;
      $display("FAIL freeze_virq: got %b want 1", vq);
    end
    sb.push_back('{vexp(0), 4'b0001});
    strobe(0, '0, '0, lat, vq, ackn, aft);
    checks++;
    if (lat !== 1 + DLY || ackn !== 1) begin
      fails++;
      $display("FAIL freeze_second: got lat=%0d acks=%0d want %0d/1", lat, ackn, 1 + DLY);
    end
  endtask

  task automatic test_drop();
    int lat, ackn;
    logic vq;
    logic [16:0] aft;
    irq_req = 4'b0100;
    sb.push_back('{vexp(2), 4'b0100});
    strobe(0, '0, 4'b0100, lat, vq, ackn, aft);
    checks++;
    if (lat !== 1 + DLY || ackn !== 1) begin
      fails++;
      $display("FAIL drop: got lat=%0d acks=%0d want %0d/1", lat, ackn, 1 + DLY);
    end
  endtask

`ifdef VIRQ_MASK_EN
  task automatic test_mask();
    logic seen;
    int lat, ackn;
    logic vq;
    logic [16:0] aft;
    irq_mask = 4'b1110;
    irq_req  = 4'b0001;
    repeat (2) @(negedge clk);
    checks++;
    if (virq !== 1'b0) begin
      fails++;
      $display("FAIL mask_virq: got %b want 0", virq);
    end
    istb = 1'b1;
    seen = 1'b0;
    repeat (16) begin
      @(negedge clk);
      seen |= iack;
    end
    checks++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL mask_noreq: got iack=%b want 0", seen);
    end
    istb = 1'b0;
    @(negedge clk);
    irq_mask = 4'b1111;
    @(negedge clk);
    checks++;
    if (virq !== 1'b1) begin
      fails++;
      $display("FAIL mask_unmask: got virq=%b want 1", virq);
    end
    sb.push_back('{vexp(0), 4'b0001});
    strobe(0, '0, '0, lat, vq, ackn, aft);
  endtask
`endif

  initial begin
    for (int i = 0; i < N; i++) irq_vec[16*i +: 16] = vexp(i);
    test_reset();
    test_single();
    test_pending();
    test_noreq();
    test_vm_init();
    test_freeze();
    test_drop();
`ifdef VIRQ_MASK_EN
    test_mask();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() !== 0) begin
      fails++;
      $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
